debug_frame_initiator: RTL and testbench

Host-side initiator for the on-chip debug frame protocol. It accepts one debug command at a time (opcode, address, data) and serializes it as a framed, checksummed byte stream onto a byte-level UART transmit interface. It then hunts for and parses the matching response frame from the UART receive byte stream, with a timeout. It sits between a byte UART pair and a command source, such as a hardware bootloader or a loopback test harness driving a debug coprocessor, and acts as the other end of the link the coprocessor responds on.

---
 rtl/debug_frame_pkg.sv | 43 ++++
 rtl/debug_frame_initiator_if.sv | 28 ++
 rtl/debug_frame_initiator.sv | 158 +++++++++++++++
 tb/tb_debug_frame_initiator.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_frame_pkg.sv
// Shared constants, error codes and state encoding for the debug frame initiator.
package debug_frame_pkg;

    localparam logic [7:0] SYNC0         = 8'h5A;
    localparam logic [7:0] SYNC1         = 8'hA5;
    localparam int         CMD_FRAME_LEN = 12;
    localparam int         RSP_FRAME_LEN = 8;

    typedef enum logic [1:0] {
        RSP_OK      = 2'd0,
        RSP_CSUM    = 2'd1,
        RSP_TIMEOUT = 2'd2
    } rsp_err_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TX    = 3'd1,
        ST_HUNT0 = 3'd2,
        ST_HUNT1 = 3'd3,
        ST_BODY  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Command frame bytes 0..10; byte 11 (checksum) comes from the running sum.
    function automatic logic [7:0] cmd_byte(input logic [3:0] idx, input logic [7:0] op,
                                            input logic [31:0] addr, input logic [31:0] data);
        case (idx)
            4'd0:    return SYNC0;
            4'd1:    return SYNC1;
            4'd2:    return op;
            4'd3:    return addr[31:24];
            4'd4:    return addr[23:16];
            4'd5:    return addr[15:8];
            4'd6:    return addr[7:0];
            4'd7:    return data[31:24];
            4'd8:    return data[23:16];
            4'd9:    return data[15:8];
            4'd10:   return data[7:0];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/debug_frame_initiator_if.sv
// Command, UART byte and response signals of the debug frame initiator.
interface debug_frame_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rsp_valid;
    logic [7:0]  rsp_status;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_error;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_addr, cmd_data, tx_ready, rx_byte, rx_valid,
        output cmd_ready, tx_byte, tx_valid, rsp_valid, rsp_status, rsp_data, rsp_error, busy
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_addr, cmd_data, tx_ready, rx_byte, rx_valid,
        input  cmd_ready, tx_byte, tx_valid, rsp_valid, rsp_status, rsp_data, rsp_error, busy
    );
endinterface

// File: rtl/debug_frame_initiator.sv
// Serializes one debug command as a checksummed frame onto the UART tx byte stream,
// then hunts for and parses the response frame from the rx byte stream with a timeout.
module debug_frame_initiator
    import debug_frame_pkg::*;
#(
    parameter int unsigned              TIMEOUT_WIDTH  = 24,
    parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    debug_frame_initiator_if.master  bus
);

    localparam logic [3:0]               TX_LAST   = 4'(CMD_FRAME_LEN - 1);
    localparam logic [3:0]               BODY_LAST = 4'(RSP_FRAME_LEN - 3);
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST  = TIMEOUT_CYCLES - 1'b1;

    state_e                   state_q, state_d;
    logic [3:0]               idx_q, idx_d;
    logic [7:0]               sum_q, sum_d;
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
    logic [7:0]               op_q, op_d;
    logic [31:0]              addr_q, addr_d;
    logic [31:0]              data_q, data_d;
    logic [7:0]               tx_byte_q, tx_byte_d;
    logic [7:0]               status_cap_q, status_cap_d;
    logic [31:0]              rdata_q, rdata_d;
    logic [7:0]               rsp_status_q, rsp_status_d;
    logic [31:0]              rsp_data_q, rsp_data_d;
    rsp_err_e                 rsp_error_q, rsp_error_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            sum_q        <= '0;
            tmo_q        <= '0;
            op_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            tx_byte_q    <= '0;
            status_cap_q <= '0;
            rdata_q      <= '0;
            rsp_status_q <= '0;
            rsp_data_q   <= '0;
            rsp_error_q  <= RSP_OK;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            tmo_q        <= tmo_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            tx_byte_q    <= tx_byte_d;
            status_cap_q <= status_cap_d;
            rdata_q      <= rdata_d;
            rsp_status_q <= rsp_status_d;
            rsp_data_q   <= rsp_data_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        tmo_d        = tmo_q;
        op_d         = op_q;
        addr_d       = addr_q;
        data_d       = data_q;
        tx_byte_d    = tx_byte_q;
        status_cap_d = status_cap_q;
        rdata_d      = rdata_q;
        rsp_status_d = rsp_status_q;
        rsp_data_d   = rsp_data_q;
        rsp_error_d  = rsp_error_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d      = bus.cmd_opcode;
                    addr_d    = bus.cmd_addr;
                    data_d    = bus.cmd_data;
                    sum_d     = '0;
                    idx_d     = '0;
                    tx_byte_d = SYNC0;
                    state_d   = ST_TX;
                end
            end
            ST_TX: begin
                if (bus.tx_ready) begin
                    if (idx_q == TX_LAST) begin
                        tmo_d   = '0;
                        state_d = ST_HUNT0;
                    end else begin
                        // Sync bytes are excluded from the checksum.
                        if (idx_q >= 4'd2) sum_d = sum_q + tx_byte_q;
                        idx_d     = idx_q + 4'd1;
                        tx_byte_d = (idx_d == TX_LAST) ? 8'h00 - sum_d
                                                       : cmd_byte(idx_d, op_q, addr_q, data_q);
                    end
                end
            end
            ST_HUNT0, ST_HUNT1, ST_BODY: begin
                // A byte arriving on the timeout edge takes priority.
                if (bus.rx_valid) begin
                    tmo_d = '0;
                    case (state_q)
                        ST_HUNT0: begin
                            if (bus.rx_byte == SYNC0) state_d = ST_HUNT1;
                        end
                        ST_HUNT1: begin
                            if (bus.rx_byte == SYNC1) begin
                                state_d = ST_BODY;
                                idx_d   = '0;
                                sum_d   = '0;
                            end else if (bus.rx_byte != SYNC0) begin
                                state_d = ST_HUNT0;
                            end
                        end
                        default: begin
                            sum_d = sum_q + bus.rx_byte;
                            idx_d = idx_q + 4'd1;
                            if (idx_q == 4'd0)       status_cap_d = bus.rx_byte;
                            else if (idx_q <= 4'd4)  rdata_d = {rdata_q[23:0], bus.rx_byte};
                            if (idx_q == BODY_LAST) begin
                                state_d      = ST_DONE;
                                rsp_status_d = status_cap_q;
                                rsp_data_d   = rdata_q;
                                rsp_error_d  = (sum_d == 8'h00) ? RSP_OK : RSP_CSUM;
                            end
                        end
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    state_d      = ST_DONE;
                    rsp_status_d = '0;
                    rsp_data_d   = '0;
                    rsp_error_d  = RSP_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.cmd_ready  = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.tx_valid   = (state_q == ST_TX);
    assign bus.tx_byte    = tx_byte_q;
    assign bus.rsp_valid  = (state_q == ST_DONE);
    assign bus.rsp_status = rsp_status_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_error  = rsp_error_q;

endmodule

// File: tb/tb_debug_frame_initiator.sv
// Directed and randomized checks of the debug frame initiator against a frame-level model.
module tb_debug_frame_initiator;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   rsp_cnt = 0;

    always #5 clk = ~clk;

    debug_frame_initiator_if bus();

    debug_frame_initiator #(.TIMEOUT_CYCLES(24'd100)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always @(negedge clk) if (bus.rsp_valid === 1'b1) rsp_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference command frame: syncs, fields MSB first, two's complement checksum.
    function automatic logic [11:0][7:0] model_cmd(input logic [7:0] op, input logic [31:0] a,
                                                   input logic [31:0] d);
        logic [11:0][7:0] f;
        int s = 0;
        f[0] = 8'h5A; f[1] = 8'hA5; f[2] = op;
        for (int i = 0; i < 4; i++) begin
            f[3 + i] = 8'((a >> (24 - 8 * i)) & 32'hFF);
            f[7 + i] = 8'((d >> (24 - 8 * i)) & 32'hFF);
        end
        for (int i = 2; i < 11; i++) s += int'(f[i]);
        f[11] = 8'((256 - (s % 256)) % 256);
        return f;
    endfunction

    function automatic logic [7:0][7:0] model_rsp(input logic [7:0] st, input logic [31:0] d,
                                                  input bit bad);
        logic [7:0][7:0] f;
        int s = 0;
        f[0] = 8'h5A; f[1] = 8'hA5; f[2] = st;
        for (int i = 0; i < 4; i++) f[3 + i] = 8'((d >> (24 - 8 * i)) & 32'hFF);
        for (int i = 2; i < 7; i++) s += int'(f[i]);
        f[7] = 8'((256 - (s % 256)) % 256) ^ {7'd0, bad};
        return f;
    endfunction

    function automatic logic [1:0] model_err(input logic [7:0][7:0] f);
        int s = 0;
        for (int i = 2; i < 8; i++) s += int'(f[i]);
        return (s % 256 == 0) ? 2'd0 : 2'd1;
    endfunction

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        chk("cmd_ready_before_cmd", bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1; bus.cmd_opcode = op; bus.cmd_addr = a; bus.cmd_data = d;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Collects 12 accepted tx bytes, checking that a stalled byte is held.
    task automatic collect_tx(input bit toggle, output logic [11:0][7:0] got,
                              output int first, output int last);
        int cyc = 0, n = 0;
        logic hold = 1'b0;
        logic [7:0] held = 8'h00;
        got = '0; first = -1; last = -1;
        while (n < 12 && cyc < 200) begin
            @(negedge clk);
            if (hold) begin
                chk("tx_hold_valid", bus.tx_valid, 1'b1);
                chk("tx_hold_byte", bus.tx_byte, held);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                got[n] = bus.tx_byte;
                if (n == 0) first = cyc;
                last = cyc;
                n++;
            end
            hold = bus.tx_valid && !bus.tx_ready;
            held = bus.tx_byte;
            @(posedge clk); #1;
            if (toggle) bus.tx_ready = ~bus.tx_ready;
            cyc++;
        end
        chk("tx_byte_count", n, 12);
        bus.tx_ready = 1'b1;
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                           input bit toggle);
        logic [11:0][7:0] got, exp;
        int first, last;
        exp = model_cmd(op, a, d);
        bus.tx_ready = 1'b1;
        send_cmd(op, a, d);
        collect_tx(toggle, got, first, last);
        for (int i = 0; i < 12; i++) chk($sformatf("tx_byte[%0d]", i), got[i], exp[i]);
        chk("tx_first_cycle", first, 0);
        if (!toggle) chk("tx_last_cycle", last, 11);
    endtask

    task automatic feed_rx(input logic [7:0] b, input int gap);
        bus.rx_byte = b; bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic check_rsp(input logic [7:0] st, input logic [31:0] d, input logic [1:0] err,
                             input int cnt0);
        @(negedge clk);
        chk("rsp_valid_pulse", bus.rsp_valid, 1'b1);
        chk("rsp_status", bus.rsp_status, st);
        chk("rsp_data", bus.rsp_data, d);
        chk("rsp_error", bus.rsp_error, err);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rsp_valid_drop", bus.rsp_valid, 1'b0);
        chk("cmd_ready_after_rsp", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;
        chk("rsp_pulse_count", rsp_cnt - cnt0, 1);
    endtask

    task automatic feed_frame(input logic [7:0][7:0] f, input int gap);
        for (int i = 0; i < 8; i++) feed_rx(f[i], (i == 7) ? 0 : gap);
    endtask

    initial begin
        logic [7:0][7:0] rf;
        logic [7:0] op, st, junk;
        logic [31:0] a, d, rd;
        int cnt0, n;
        bit bad, tog;

        bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_addr = '0; bus.cmd_data = '0;
        bus.tx_ready = 1'b1; bus.rx_byte = '0; bus.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", bus.cmd_ready, 1'b1);
        chk("reset_tx_valid", bus.tx_valid, 1'b0);
        chk("reset_tx_byte", bus.tx_byte, 8'h00);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("reset_rsp_data", bus.rsp_data, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic write
        run_cmd(8'h02, 32'h8000_0000, 32'hDEAD_BEEF, 1'b0);
        chk("basic_csum_const", model_cmd(8'h02, 32'h8000_0000, 32'hDEAD_BEEF)[11], 8'h46);
        cnt0 = rsp_cnt;
        rf = model_rsp(8'h00, 32'h1234_5678, 1'b0);
        chk("basic_rsp_csum_const", rf[7], 8'hEC);
        feed_frame(rf, 0);
        check_rsp(8'h00, 32'h1234_5678, 2'd0, cnt0);

        // Backpressure; the previous response must be held meanwhile
        run_cmd(8'h02, 32'h8000_0000, 32'hDEAD_BEEF, 1'b1);
        chk("rsp_data_held", bus.rsp_data, 32'h1234_5678);
        cnt0 = rsp_cnt;
        feed_frame(model_rsp(8'h00, 32'h1234_5678, 1'b0), 0);
        check_rsp(8'h00, 32'h1234_5678, 2'd0, cnt0);

        // Sync hunting through a noisy prefix
        run_cmd(8'h02, 32'h8000_0000, 32'hDEAD_BEEF, 1'b0);
        cnt0 = rsp_cnt;
        feed_rx(8'hFF, 0); feed_rx(8'h5A, 0); feed_rx(8'h5A, 0); feed_rx(8'h33, 0); feed_rx(8'h5A, 0);
        feed_frame(model_rsp(8'h00, 32'h1234_5678, 1'b0), 0);
        check_rsp(8'h00, 32'h1234_5678, 2'd0, cnt0);

        // Checksum error
        run_cmd(8'h02, 32'h8000_0000, 32'hDEAD_BEEF, 1'b0);
        cnt0 = rsp_cnt;
        rf = model_rsp(8'h00, 32'h1234_5678, 1'b1);
        chk("bad_csum_const", rf[7], 8'hED);
        feed_frame(rf, 0);
        check_rsp(8'h00, 32'h1234_5678, 2'd1, cnt0);

        // Timeout: 100 cycles after the last strobe
        run_cmd(8'h01, 32'h0000_1000, 32'h0, 1'b0);
        cnt0 = rsp_cnt;
        feed_rx(8'h5A, 0); feed_rx(8'hA5, 0); feed_rx(8'h00, 0);
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) break;
            n++;
        end
        chk("timeout_latency", n, 100);
        chk("timeout_error", bus.rsp_error, 2'd2);
        chk("timeout_status", bus.rsp_status, 8'h00);
        chk("timeout_data", bus.rsp_data, 32'h0);
        @(negedge clk);
        chk("timeout_cmd_ready", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;
        chk("timeout_pulse_count", rsp_cnt - cnt0, 1);

        // Reset during the tx of byte 5
        cnt0 = rsp_cnt;
        bus.tx_ready = 1'b1;
        send_cmd(8'h03, 32'h1111_2222, 32'h3333_4444);
        repeat (5) @(posedge clk);
        #2;
        chk("pre_reset_tx_byte5", bus.tx_byte, 8'h22);
        reset_n = 1'b0;
        #1;
        chk("async_reset_tx_valid", bus.tx_valid, 1'b0);
        chk("async_reset_busy", bus.busy, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_cmd_ready", bus.cmd_ready, 1'b1);
        chk("post_reset_no_rsp", rsp_cnt - cnt0, 0);
        @(posedge clk); #1;
        run_cmd(8'h02, 32'h8000_0000, 32'hDEAD_BEEF, 1'b0);
        cnt0 = rsp_cnt;
        feed_frame(model_rsp(8'h00, 32'h1234_5678, 1'b0), 0);
        check_rsp(8'h00, 32'h1234_5678, 2'd0, cnt0);

        // Randomized commands and responses
        for (int t = 0; t < 8; t++) begin
            op = 8'($urandom); a = $urandom; d = $urandom;
            st = 8'($urandom); rd = $urandom;
            bad = 1'($urandom); tog = 1'($urandom);
            run_cmd(op, a, d, tog);
            cnt0 = rsp_cnt;
            repeat ($urandom_range(0, 4)) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h00;
                feed_rx(junk, $urandom_range(0, 3));
            end
            rf = model_rsp(st, rd, bad);
            feed_frame(rf, $urandom_range(0, 3));
            check_rsp(st, rd, model_err(rf), cnt0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
